// File: rtl/pc_sequencer.sv
// Program-counter sequencer: fetches one instruction per PC, then lets the
// external PC-select mux decide the next PC (increment/branch/jump/hold).
module pc_sequencer #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int unsigned ACK_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] newPC,
    input  logic        jumpValid,
    input  logic        branchTaken,
    input  logic        stall,
    input  logic        imemAck,
    input  logic [31:0] imemData,
    output logic [31:0] PC,
    output logic [1:0]  PCSource,
    output logic        imemReq,
    output logic [31:0] imemAddr,
    output logic [31:0] instr,
    output logic        instrValid,
    output logic [15:0] fetchCount,
    output logic        fetchErr
);

    typedef enum logic [1:0] {START, FETCH, DECIDE, HALT} state_t;

    localparam logic [1:0] SEL_INC    = 2'b00;
    localparam logic [1:0] SEL_BRANCH = 2'b01;
    localparam logic [1:0] SEL_JUMP   = 2'b10;
    localparam logic [1:0] SEL_HOLD   = 2'b11;

    // wait_cnt holds the number of ack-less cycles already spent in FETCH, so
    // the cycle that sees it at ACK_TIMEOUT-1 is the last one allowed.
    localparam logic [7:0] WAIT_LAST = 8'(ACK_TIMEOUT - 1);

    state_t     state;
    state_t     state_next;
    logic [7:0] wait_cnt;
    logic       fetch_done;
    logic       fetch_timeout;
    logic       pc_advance;

    function automatic logic [1:0] select_source(input logic hold, input logic jump,
                                                 input logic branch);
        if (hold)
            return SEL_HOLD;
        else if (jump)
            return SEL_JUMP;
        else if (branch)
            return SEL_BRANCH;
        else
            return SEL_INC;
    endfunction

    assign fetch_done    = (state == FETCH) && imemAck;
    assign fetch_timeout = (state == FETCH) && !imemAck && (wait_cnt == WAIT_LAST);
    assign pc_advance    = (state == DECIDE) && !stall;

    assign imemReq  = (state == FETCH);
    assign imemAddr = PC;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= START;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        PCSource   = SEL_HOLD;
        case (state)
            START:  state_next = FETCH;
            FETCH: begin
                // An ack arriving on the timeout cycle still completes the fetch.
                if (imemAck)
                    state_next = DECIDE;
                else if (fetch_timeout)
                    state_next = HALT;
            end
            DECIDE: begin
                PCSource = select_source(stall, jumpValid, branchTaken);
                if (!stall)
                    state_next = FETCH;
            end
            HALT:   state_next = HALT;
            default: state_next = START;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            PC         <= RESET_PC;
            instr      <= '0;
            instrValid <= 1'b0;
            fetchCount <= '0;
            fetchErr   <= 1'b0;
            wait_cnt   <= '0;
        end else begin
            instrValid <= fetch_done;
            if (pc_advance)
                PC <= newPC;
            if (fetch_done) begin
                instr      <= imemData;
                fetchCount <= fetchCount + 16'd1;
            end
            if (fetch_timeout)
                fetchErr <= 1'b1;
            if (state == FETCH)
                wait_cnt <= imemAck ? 8'd0 : wait_cnt + 8'd1;
        end
    end

endmodule
